// File: rtl/alu_ctrl_seq.sv
// EX-stage ALU control: decodes ALUOp/funct into a registered operation code and
// sequences multi-cycle integer MUL and FP add/sub/mul with start pulse, latency counter and stall.

module alu_ctrl_seq_param_check #(
    parameter int MUL_LAT = 4,
    parameter int FP_LAT  = 6
) ();
    // A zero latency would leave the WAIT state with nothing to count.
    if (MUL_LAT < 1 || FP_LAT < 1) begin : g_bad_lat
        $error("alu_ctrl_seq: MUL_LAT and FP_LAT must be >= 1");
    end
endmodule

module alu_ctrl_seq #(
    parameter int OPW     = 4,
    parameter int FUNCW   = 6,
    parameter int MUL_LAT = 4,
    parameter int FP_LAT  = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    input  logic [1:0]       ALUOp,
    input  logic [FUNCW-1:0] function_bits,
    input  logic             flush,
    output logic [OPW-1:0]   ALUOperation,
    output logic             op_valid,
    output logic             unit_start,
    output logic             fp_sel,
    output logic             busy,
    output logic             ready,
    output logic             stall,
    output logic             illegal
);
    localparam int MAX_LAT = (MUL_LAT > FP_LAT) ? MUL_LAT : FP_LAT;
    localparam int CNTW    = $clog2(MAX_LAT + 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    localparam logic [CNTW-1:0] MUL_LAT_C = CNTW'(MUL_LAT);
    localparam logic [CNTW-1:0] FP_LAT_C  = CNTW'(FP_LAT);
    localparam logic [CNTW-1:0] CNT_ONE   = CNTW'(1);
    localparam logic [CNTW-1:0] CNT_ZERO  = CNTW'(0);

    localparam logic [FUNCW-1:0] F_ADD  = FUNCW'(6'b100000);
    localparam logic [FUNCW-1:0] F_SUB  = FUNCW'(6'b100010);
    localparam logic [FUNCW-1:0] F_MUL  = FUNCW'(6'b100100);
    localparam logic [FUNCW-1:0] F_XOR  = FUNCW'(6'b100101);
    localparam logic [FUNCW-1:0] F_SLT  = FUNCW'(6'b101010);
    localparam logic [FUNCW-1:0] F_FADD = FUNCW'(6'b000000);
    localparam logic [FUNCW-1:0] F_FSUB = FUNCW'(6'b000001);
    localparam logic [FUNCW-1:0] F_FMUL = FUNCW'(6'b000010);

    alu_ctrl_seq_param_check #(.MUL_LAT(MUL_LAT), .FP_LAT(FP_LAT)) u_param_check ();

    logic [0:0]      state_r;
    logic [CNTW-1:0] cnt_r;
    logic [OPW-1:0]  alu_op_r;
    logic            op_valid_r;
    logic            unit_start_r;
    logic            fp_sel_r;
    logic            illegal_r;

    logic [OPW-1:0]  code_s;
    logic            multi_s;
    logic            fp_s;
    logic            illegal_s;
    logic [CNTW-1:0] lat_s;
    logic            busy_s;
    logic            accept_s;

    // Instruction decode into operation code and routing/latency attributes.
    always_comb begin
        code_s    = OPW'(4'b1111);
        multi_s   = 1'b0;
        fp_s      = 1'b0;
        illegal_s = 1'b1;
        case (ALUOp)
            2'b00: begin code_s = OPW'(4'b0010); illegal_s = 1'b0; end
            2'b01: begin code_s = OPW'(4'b0110); illegal_s = 1'b0; end
            2'b10: begin
                case (function_bits)
                    F_ADD: begin code_s = OPW'(4'b0010); illegal_s = 1'b0; end
                    F_SUB: begin code_s = OPW'(4'b0110); illegal_s = 1'b0; end
                    F_MUL: begin code_s = OPW'(4'b0000); illegal_s = 1'b0; multi_s = 1'b1; end
                    F_XOR: begin code_s = OPW'(4'b0011); illegal_s = 1'b0; end
                    F_SLT: begin code_s = OPW'(4'b0111); illegal_s = 1'b0; end
                    default: illegal_s = 1'b1;
                endcase
            end
            2'b11: begin
                case (function_bits)
                    F_FADD: begin code_s = OPW'(4'b1010); illegal_s = 1'b0; multi_s = 1'b1; fp_s = 1'b1; end
                    F_FSUB: begin code_s = OPW'(4'b1110); illegal_s = 1'b0; multi_s = 1'b1; fp_s = 1'b1; end
                    F_FMUL: begin code_s = OPW'(4'b1000); illegal_s = 1'b0; multi_s = 1'b1; fp_s = 1'b1; end
                    default: illegal_s = 1'b1;
                endcase
            end
            default: illegal_s = 1'b1;
        endcase
    end

    assign lat_s    = fp_s ? FP_LAT_C : MUL_LAT_C;
    assign busy_s   = (state_r == ST_WAIT);
    assign accept_s = valid_in & ~busy_s & ~flush;

    // Sequencer: accept, latency countdown, and flush/reset abort.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            cnt_r        <= CNT_ZERO;
            alu_op_r     <= OPW'(4'b0000);
            op_valid_r   <= 1'b0;
            unit_start_r <= 1'b0;
            fp_sel_r     <= 1'b0;
            illegal_r    <= 1'b0;
        end else if (flush) begin
            state_r      <= ST_IDLE;
            cnt_r        <= CNT_ZERO;
            op_valid_r   <= 1'b0;
            unit_start_r <= 1'b0;
            illegal_r    <= 1'b0;
        end else begin
            op_valid_r   <= 1'b0;
            unit_start_r <= 1'b0;
            illegal_r    <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        alu_op_r <= code_s;
                        fp_sel_r <= fp_s;
                        if (illegal_s) begin
                            illegal_r <= 1'b1;
                        end else if (multi_s && (lat_s > CNT_ONE)) begin
                            unit_start_r <= 1'b1;
                            cnt_r        <= lat_s - CNT_ONE;
                            state_r      <= ST_WAIT;
                        end else begin
                            op_valid_r <= 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    // Exiting on <=1 rather than ==1 keeps a corrupted counter from wrapping.
                    if (cnt_r <= CNT_ONE) begin
                        op_valid_r <= 1'b1;
                        cnt_r      <= CNT_ZERO;
                        state_r    <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= CNT_ZERO;
                end
            endcase
        end
    end

    assign ALUOperation = alu_op_r;
    assign op_valid     = op_valid_r;
    assign unit_start   = unit_start_r;
    assign fp_sel       = fp_sel_r;
    assign illegal      = illegal_r;
    assign busy         = busy_s;
    assign ready        = ~busy_s;
    assign stall        = valid_in & busy_s;
endmodule

// File: doc/alu_ctrl_seq.md
# alu_ctrl_seq

Parametrised, sequential successor to the combinational ALU control decoder. It decodes ALUOp and function bits into a registered ALU operation code, extended with an FP mode. It sequences multi-cycle operations (integer MUL, FP add/sub/mul) with a start pulse, a latency counter and a pipeline stall. It sits in the EX stage between the ID/EX pipeline register and the integer/FP execution units.

## Interface
- OPW, 4, width of ALUOperation code
- FUNCW, 6, width of function_bits
- MUL_LAT, 4, integer multiply latency in cycles (>=1)
- FP_LAT, 6, FP add/sub/mul latency in cycles (>=1)
- CNTW, derived = $clog2(max(MUL_LAT,FP_LAT)+1), latency counter width (localparam)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- valid_in  in  1  instruction present at EX input
- ALUOp  in  2  00 mem/addi, 01 branch, 10 R-type, 11 FP
- function_bits  in  FUNCW  funct field
- flush  in  1  synchronous abort of current/incoming op
- ALUOperation  out  OPW  registered operation code
- op_valid  out  1  1-cycle pulse: result of ALUOperation available this cycle
- unit_start  out  1  1-cycle pulse to multi-cycle unit
- fp_sel  out  1  1 = op routed to FP unit
- busy  out  1  multi-cycle op in flight
- ready  out  1  = !busy (combinational)
- stall  out  1  = valid_in & busy (combinational)
- illegal  out  1  1-cycle pulse, undecodable op accepted

## Operation
- Decode (accepted when valid_in & ready & !flush):
  - ALUOp 00 -> ADD 0010; 01 -> SUB 0110
  - ALUOp 10: funct 100000 ADD 0010, 100010 SUB 0110, 100100 MUL 0000 (multi-cycle, MUL_LAT), 100101 XOR 0011, 101010 SLT 0111
  - ALUOp 11: funct 000000 FADD 1010, 000001 FSUB 1110, 000010 FMUL 1000 (all multi-cycle, FP_LAT, fp_sel=1)
  - anything else: ALUOperation 1111, illegal pulse, no op_valid, no busy
- States: IDLE, WAIT.
  - IDLE, accept single-cycle or multi-cycle op with latency 1: register code, op_valid next cycle, stay IDLE
  - IDLE, accept multi-cycle op with LAT>1: register code, unit_start pulse, load counter LAT-1, go WAIT
  - WAIT: decrement counter each cycle; at counter==1 next cycle op_valid=1 and return IDLE
- ALUOperation and fp_sel hold last accepted value until next accept.
- flush: highest priority after reset; next cycle busy=0, state IDLE, counter 0, op_valid/unit_start/illegal=0; ALUOperation retained. An op presented with flush is not accepted.
- reset: same as flush, plus ALUOperation=0000, fp_sel=0.
- Unsupported LAT=0 is a parameter error (elaboration assertion).

## Timing
- Reset values: ALUOperation 0000, op_valid 0, unit_start 0, fp_sel 0, busy 0, ready 1, stall 0, illegal 0.
- Accept at edge T (inputs sampled). Single-cycle: ALUOperation/op_valid valid in cycle T+1.
- Multi-cycle latency L: ALUOperation, unit_start, busy=1 in cycle T+1; busy stays high through T+L-1; op_valid=1 and busy=0 in cycle T+L; new op can be accepted at edge ending cycle T+L (back-to-back, no bubble).
- Back-to-back single-cycle ops: one accept per cycle, op_valid continuous.
- While busy, valid_in is ignored and stall=1; upstream must hold instruction.
- Counter never wraps; WAIT with counter at 1 always exits.

## Test plan
- Reset, then ALUOp=10 funct=100000 valid 1 cycle -> next cycle ALUOperation=0010, op_valid=1, busy=0, unit_start=0.
- MUL (ALUOp=10, funct=100100), MUL_LAT=4, then ADD held at input -> unit_start in T+1, busy T+1..T+3, stall=1 those cycles, op_valid=1 with 0000 at T+4, ADD accepted at end of T+4, op_valid with 0010 at T+5.
- FMUL (ALUOp=11, funct=000010), FP_LAT=6 -> fp_sel=1, ALUOperation=1000, op_valid exactly 6 cycles after accept, single pulse.
- ALUOp=10 funct=111111 -> ALUOperation=1111, illegal=1 for one cycle, op_valid=0, busy=0.
- FADD accepted, flush asserted 2 cycles later -> busy=0 next cycle, no op_valid ever for FADD; subsequent XOR decodes to 0011 normally.
- MUL in flight, reset asserted mid-op -> next cycle all outputs at reset values, ready=1, no stray op_valid.
